vga_mode_ctrl: RTL

Display-mode sequencer for the VGA output datapath. Debounces two push-buttons (next/previous) and turns each press into a pending mode-change request. Commits the request to the 3-bit mode select (`state`) only at a frame boundary, so a pattern change never tears mid-frame. Sits between the board buttons and the datapath's `state` input, clocked from the same `sys_clk` as the VGA timing.

---
 rtl/vga_mode_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vga_mode_ctrl.sv
// Display-mode sequencer: debounced next/prev buttons queue a mode change that is
// committed only at a frame boundary. Optional auto-advance via MODE_AUTO_CYCLE_EN.
module vga_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned DWELL_FRAMES    = 300
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       vga_vs,
  output logic [2:0] state,
  output logic       mode_update,
  output logic       req_pending
);

  localparam int unsigned      CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       LAST_MODE = 4'(NUM_MODES - 1);

  localparam logic [1:0] PEND_NONE = 2'd0;
  localparam logic [1:0] PEND_NEXT = 2'd1;
  localparam logic [1:0] PEND_PREV = 2'd2;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) || NUM_MODES < 2 || NUM_MODES > 8 ||
      DWELL_FRAMES < 1 || DWELL_FRAMES > 1023) begin : g_param_check
    $error("vga_mode_ctrl: parameter out of legal range");
  end

  logic [1:0] btn_raw;
  logic [1:0] press;   // bit 0 = next, bit 1 = prev
  assign btn_raw = {btn_prev, btn_next};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             meta_reg;
      logic             sync_reg;
      logic             stable_reg;
      logic             stable_last_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          meta_reg        <= 1'b0;
          sync_reg        <= 1'b0;
          stable_reg      <= 1'b0;
          stable_last_reg <= 1'b0;
          cnt_reg         <= '0;
        end else begin
          meta_reg        <= btn_raw[gi];
          sync_reg        <= meta_reg;
          stable_last_reg <= stable_reg;
          // Any return to the stable level restarts the count, rejecting short glitches.
          if (sync_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = stable_reg & ~stable_last_reg;
    end
  endgenerate

  logic vs_meta_reg;
  logic vs_sync_reg;
  logic vs_last_reg;
  logic frame_tick;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vs_meta_reg <= 1'b0;
      vs_sync_reg <= 1'b0;
      vs_last_reg <= 1'b0;
    end else begin
      vs_meta_reg <= vga_vs;
      vs_sync_reg <= vs_meta_reg;
      vs_last_reg <= vs_sync_reg;
    end
  end

  assign frame_tick = vs_last_reg & ~vs_sync_reg;

  logic [1:0] pending_reg;
  logic [1:0] pending_next;
  logic [2:0] state_reg;
  logic       mode_update_reg;
  logic [3:0] state_ext;
  logic [3:0] inc_mode;
  logic [3:0] dec_mode;
  logic       apply_req;
  logic       auto_step;

  // A press coinciding with frame_tick is queued for the next frame, not the current one.
  always_comb begin
    pending_next = pending_reg;
    if (press[0] && press[1]) begin
      pending_next = PEND_NONE;
    end else if (press[0]) begin
      pending_next = PEND_NEXT;
    end else if (press[1]) begin
      pending_next = PEND_PREV;
    end else if (frame_tick) begin
      pending_next = PEND_NONE;
    end
  end

  assign state_ext = {1'b0, state_reg};
  assign inc_mode  = (state_ext >= LAST_MODE) ? 4'd0 : state_ext + 4'd1;
  assign dec_mode  = (state_ext == 4'd0) ? LAST_MODE : state_ext - 4'd1;
  assign apply_req = frame_tick && (pending_reg != PEND_NONE);

`ifdef MODE_AUTO_CYCLE_EN
  localparam logic [9:0] DWELL_LAST = 10'(DWELL_FRAMES - 1);
  logic [9:0] frame_cnt_reg;

  assign auto_step = frame_tick && (pending_reg == PEND_NONE) && (frame_cnt_reg == DWELL_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      frame_cnt_reg <= '0;
    end else if ((|press) || apply_req || auto_step) begin
      frame_cnt_reg <= '0;
    end else if (frame_tick) begin
      frame_cnt_reg <= frame_cnt_reg + 10'd1;
    end
  end
`else
  assign auto_step = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pending_reg     <= PEND_NONE;
      state_reg       <= 3'd0;
      mode_update_reg <= 1'b0;
    end else begin
      pending_reg     <= pending_next;
      mode_update_reg <= apply_req | auto_step;
      if (apply_req) begin
        state_reg <= (pending_reg == PEND_PREV) ? dec_mode[2:0] : inc_mode[2:0];
      end else if (auto_step) begin
        state_reg <= inc_mode[2:0];
      end
    end
  end

  assign state       = state_reg;
  assign mode_update = mode_update_reg;
  assign req_pending = (pending_reg != PEND_NONE);

endmodule
